// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for one counter_updown_mod stage.
// The master drives the controls; the counter stage is the slave.
interface counter_updown_mod_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clr_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic             pulse_i;
    logic             dir_i;
    logic [WIDTH-1:0] count_o;
    logic             cout_o;
    logic             tc_o;

    modport master (
        output clr_i,
        output load_i,
        output load_val_i,
        output pulse_i,
        output dir_i,
        input  count_o,
        input  cout_o,
        input  tc_o
    );

    modport slave (
        input  clr_i,
        input  load_i,
        input  load_val_i,
        input  pulse_i,
        input  dir_i,
        output count_o,
        output cout_o,
        output tc_o
    );
endinterface

// File: rtl/counter_updown_mod.sv
// Modulo up/down counter stage with clear, clamped load and cascade terminal count.
// Define COUNTER_SATURATE_EN to hold at the range ends instead of wrapping.
module counter_updown_mod #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DATA_MAX = 59
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_updown_mod_if.slave  bus
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(DATA_MAX);

    logic [WIDTH-1:0] count_q, count_d;
    logic             cout_q, cout_d;
    logic             at_max, at_zero;
    logic [WIDTH-1:0] load_clamped;

    assign at_max       = (count_q == MaxVal);
    assign at_zero      = (count_q == '0);
    assign load_clamped = (bus.load_val_i > MaxVal) ? MaxVal : bus.load_val_i;

    always_comb begin
        count_d = count_q;
        cout_d  = 1'b0;
        if (bus.clr_i) begin
            count_d = '0;
        end else if (bus.load_i) begin
            count_d = load_clamped;
        end else if (bus.pulse_i) begin
            if (bus.dir_i) begin
                if (at_max) begin
                    // Blocked or wrapping step at the top end; both flag cout.
`ifdef COUNTER_SATURATE_EN
                    count_d = MaxVal;
`else
                    count_d = '0;
`endif
                    cout_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
                    count_d = '0;
`else
                    count_d = MaxVal;
`endif
                    cout_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            cout_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.count_o = count_q;
    assign bus.cout_o  = cout_q;
    // Unregistered so a following stage can step on the same edge this one wraps.
    assign bus.tc_o    = (bus.dir_i & at_max) | (~bus.dir_i & at_zero);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: two cascaded stages (mod 60, mod 24) against a modulo-arithmetic model.
module tb_counter_updown_mod;

    localparam int M1 = 59;
    localparam int M2 = 23;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_en   = 0;

    counter_updown_mod_if #(.WIDTH(8)) bus1 ();
    counter_updown_mod_if #(.WIDTH(8)) bus2 ();

    assign bus2.pulse_i = bus1.pulse_i & bus1.tc_o;
    assign bus2.dir_i   = bus1.dir_i;

    counter_updown_mod #(.WIDTH(8), .DATA_MAX(M1)) u_sec (.clk(clk), .rst(rst), .bus(bus1));
    counter_updown_mod #(.WIDTH(8), .DATA_MAX(M2)) u_min (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: counting as arithmetic modulo (mx+1), or clamped in saturate mode.
    task automatic model_step(inout int cnt, output bit cout, input bit clr, input bit ld,
                              input int lv, input bit pulse, input bit dir, input int mx);
        cout = 0;
        if (clr) cnt = 0;
        else if (ld) cnt = (lv > mx) ? mx : lv;
        else if (pulse) begin
            if (dir) begin
                cout = (cnt == mx);
`ifdef COUNTER_SATURATE_EN
                cnt = (cnt + 1 > mx) ? mx : cnt + 1;
`else
                cnt = (cnt + 1) % (mx + 1);
`endif
            end else begin
                cout = (cnt == 0);
`ifdef COUNTER_SATURATE_EN
                cnt = (cnt - 1 < 0) ? 0 : cnt - 1;
`else
                cnt = (cnt + mx) % (mx + 1);
`endif
            end
        end
    endtask

    function automatic bit model_tc(input int cnt, input bit dir, input int mx);
        return dir ? (cnt == mx) : (cnt == 0);
    endfunction

    int m1, m2;
    bit mc1, mc2;
    bit p2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1 = 0; m2 = 0; mc1 = 0; mc2 = 0;
        end else begin
            p2 = bus1.pulse_i && model_tc(m1, bus1.dir_i, M1);
            model_step(m1, mc1, bus1.clr_i, bus1.load_i, int'(bus1.load_val_i),
                       bus1.pulse_i, bus1.dir_i, M1);
            model_step(m2, mc2, bus2.clr_i, bus2.load_i, int'(bus2.load_val_i),
                       p2, bus1.dir_i, M2);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("s1_count", bus1.count_o, m1);
            chk("s1_cout",  bus1.cout_o,  mc1);
            chk("s1_tc",    bus1.tc_o,    model_tc(m1, bus1.dir_i, M1));
            chk("s2_count", bus2.count_o, m2);
            chk("s2_cout",  bus2.cout_o,  mc2);
            chk("s2_tc",    bus2.tc_o,    model_tc(m2, bus1.dir_i, M2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.clr_i = 0; bus1.load_i = 0; bus1.load_val_i = 0; bus1.pulse_i = 0; bus1.dir_i = 1;
        bus2.clr_i = 0; bus2.load_i = 0; bus2.load_val_i = 0;
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        step(); step();
        chk("reset_count", bus1.count_o, 0);
        chk("reset_cout",  bus1.cout_o,  0);
        rst = 1;
        cmp_en = 1;
        step();

        // Asynchronous reset mid-count
        bus1.load_i = 1; bus1.load_val_i = 7;
        step();
        bus1.load_i = 0;
        chk("load7", bus1.count_o, 7);
        #2 rst = 0;
        #1;
        chk("async_rst_count", bus1.count_o, 0);
        chk("async_rst_cout",  bus1.cout_o,  0);
        step();
        rst = 1;
        step();

        // Up from 0 through the wrap
        bus1.clr_i = 1; bus2.clr_i = 1;
        step();
        bus1.clr_i = 0; bus2.clr_i = 0;
        bus1.dir_i = 1; bus1.pulse_i = 1;
        for (int i = 0; i < 59; i++) step();
        chk("up_59", bus1.count_o, 59);
        chk("tc_at_59", bus1.tc_o, 1);
        step();
`ifdef COUNTER_SATURATE_EN
        chk("sat_up_hold", bus1.count_o, 59);
`else
        chk("up_wrap", bus1.count_o, 0);
`endif
        chk("wrap_cout", bus1.cout_o, 1);
        bus1.pulse_i = 0;
        step();
        chk("cout_one_cycle", bus1.cout_o, 0);

        // Down from 0
        bus1.clr_i = 1;
        step();
        bus1.clr_i = 0; bus1.dir_i = 0; bus1.pulse_i = 1;
        step();
`ifdef COUNTER_SATURATE_EN
        chk("sat_down_hold", bus1.count_o, 0);
        chk("sat_down_cout", bus1.cout_o, 1);
`else
        chk("down_wrap", bus1.count_o, 59);
        chk("down_wrap_cout", bus1.cout_o, 1);
        step();
        chk("down_58", bus1.count_o, 58);
        chk("down_58_cout", bus1.cout_o, 0);
`endif
        bus1.pulse_i = 0;

        // Clamped load, then clear overriding load and pulse
        bus1.load_i = 1; bus1.load_val_i = 75;
        step();
        chk("load_clamp", bus1.count_o, 59);
        bus1.clr_i = 1; bus1.pulse_i = 1;
        step();
        chk("clr_over_load", bus1.count_o, 0);
        bus1.clr_i = 0; bus1.load_i = 0; bus1.pulse_i = 0;

        // Cascade 58/23 counting up
        bus1.load_i = 1; bus1.load_val_i = 58; bus2.load_i = 1; bus2.load_val_i = 23;
        step();
        bus1.load_i = 0; bus2.load_i = 0; bus1.dir_i = 1; bus1.pulse_i = 1;
        step();
        chk("casc_s1_59", bus1.count_o, 59);
        chk("casc_s2_23", bus2.count_o, 23);
        chk("casc_s2_tc", bus2.tc_o, 1);
        step();
`ifdef COUNTER_SATURATE_EN
        chk("casc_s1_hold", bus1.count_o, 59);
        chk("casc_s2_hold", bus2.count_o, 23);
`else
        chk("casc_s1_0", bus1.count_o, 0);
        chk("casc_s2_0", bus2.count_o, 0);
`endif
        chk("casc_s1_cout", bus1.cout_o, 1);
        chk("casc_s2_cout", bus2.cout_o, 1);
        bus1.pulse_i = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus1.clr_i      = ($urandom_range(0, 40) == 0);
            bus1.load_i     = ($urandom_range(0, 20) == 0);
            bus1.load_val_i = 8'($urandom_range(0, 255));
            bus1.pulse_i    = ($urandom_range(0, 3) != 0);
            bus1.dir_i      = ($urandom_range(0, 9) < 7);
            bus2.clr_i      = ($urandom_range(0, 60) == 0);
            bus2.load_i     = ($urandom_range(0, 30) == 0);
            bus2.load_val_i = 8'($urandom_range(0, 40));
            step();
        end
        idle_inputs();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
